// File: rtl/axil_tile_pkg.sv
// Shared response codes, FSM state types and the byte-lane merge helper
// for the per-tile AXI4-Lite register file.
package axil_tile_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0] old,
    input logic [DATA_W-1:0] wdata,
    input logic [STRB_W-1:0] wstrb
  );
    logic [DATA_W-1:0] merged;
    merged = old;
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_tile_regs.sv
// AXI4-Lite slave register file for one tile: RW control registers at the
// low indices, RO status words at the top, DECERR beyond NREGS.
module axil_tile_regs
  import axil_tile_pkg::*;
#(
  parameter int AXI_OUTADR = 8,
  parameter int BW         = 32,
  parameter int BWB        = 4,
  parameter int NREGS      = 16,
  parameter int NRO        = 4
) (
  input  logic                        clk_control,
  input  logic                        rst,
  input  logic [AXI_OUTADR-1:0]       S_AXI_AWADDR,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [BW-1:0]               S_AXI_WDATA,
  input  logic [BWB-1:0]              S_AXI_WSTRB,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [AXI_OUTADR-1:0]       S_AXI_ARADDR,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [BW-1:0]               S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [BW*(NREGS-NRO)-1:0]   ctrl_regs,
  output logic [NREGS-NRO-1:0]        wr_pulse,
  input  logic [BW*NRO-1:0]           status_in,
  output wr_state_t                   wr_state_dbg,
  output rd_state_t                   rd_state_dbg
);

  localparam int IW  = AXI_OUTADR - 2;
  localparam int NRW = NREGS - NRO;

  // Handshake rule on every channel: a transfer happens on a rising edge of
  // clk_control where VALID and READY are both high; VALID/payload from the
  // source stay stable until then, and BVALID/RVALID hold until accepted.

  wr_state_t              wr_state, wr_next;
  rd_state_t              rd_state, rd_next;
  logic                   aw_held, w_held;
  logic [AXI_OUTADR-1:0]  aw_addr_q;
  logic [BW-1:0]          wdata_q;
  logic [BWB-1:0]         wstrb_q;
  logic [1:0]             bresp_q, rresp_q;
  logic [BW-1:0]          rdata_q;
  logic [BW*NRW-1:0]      ctrl_q;

  logic                   aw_hs, w_hs, commit, b_hs, ar_hs, r_hs;
  logic [AXI_OUTADR-1:0]  wr_addr;
  logic [BW-1:0]          wr_data;
  logic [BWB-1:0]         wr_strb;
  logic [IW-1:0]          wr_idx, rd_idx;
  logic [1:0]             wr_resp, rd_resp;
  logic [BW-1:0]          rd_val;
  logic                   unused_addr_bits;

  function automatic logic [1:0] decode_resp(input logic [IW-1:0] idx,
                                             input logic is_write);
    if (int'(idx) < NRW)        return RESP_OKAY;
    else if (int'(idx) < NREGS) return is_write ? RESP_SLVERR : RESP_OKAY;
    else                        return RESP_DECERR;
  endfunction

  assign S_AXI_AWREADY = !rst && !aw_held && (wr_state != WR_RESP);
  assign S_AXI_WREADY  = !rst && !w_held  && (wr_state != WR_RESP);
  assign S_AXI_ARREADY = !rst && (rd_state == RD_IDLE);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign b_hs  = S_AXI_BVALID  && S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;

  // A channel's payload comes from its holding register if it arrived
  // earlier, otherwise straight from the bus on this edge.
  assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_held  ? wdata_q   : S_AXI_WDATA;
  assign wr_strb = w_held  ? wstrb_q   : S_AXI_WSTRB;
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_idx  = wr_addr[AXI_OUTADR-1:2];
  assign wr_resp = decode_resp(wr_idx, 1'b1);

  assign unused_addr_bits = ^{wr_addr[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: begin
        if (commit)             wr_next = WR_RESP;
        else if (aw_hs || w_hs) wr_next = WR_WAIT;
      end
      WR_WAIT: if (commit) wr_next = WR_RESP;
      WR_RESP: if (b_hs)   wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_control) begin
    if (rst) begin
      wr_state  <= WR_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      ctrl_q    <= '0;
      wr_pulse  <= '0;
    end else begin
      wr_state <= wr_next;
      wr_pulse <= '0;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= wr_resp;
        for (int i = 0; i < NRW; i++) begin
          if (int'(wr_idx) == i) begin
            ctrl_q[BW*i +: BW] <= strb_merge(ctrl_q[BW*i +: BW], wr_data, wr_strb);
            wr_pulse[i]        <= |wr_strb;
          end
        end
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= S_AXI_WDATA;
          wstrb_q <= S_AXI_WSTRB;
        end
      end
    end
  end

  assign rd_idx  = S_AXI_ARADDR[AXI_OUTADR-1:2];
  assign rd_resp = decode_resp(rd_idx, 1'b0);

  // Reads see the register contents before any write committing on the same edge.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NRW; i++) begin
      if (int'(rd_idx) == i) rd_val = ctrl_q[BW*i +: BW];
    end
    for (int j = 0; j < NRO; j++) begin
      if (int'(rd_idx) == NRW + j) rd_val = status_in[BW*j +: BW];
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_RESP;
      RD_RESP: if (r_hs)  rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_control) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        rdata_q <= rd_val;
        rresp_q <= rd_resp;
      end
    end
  end

  assign S_AXI_BVALID = (wr_state == WR_RESP);
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = (rd_state == RD_RESP);
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign ctrl_regs    = ctrl_q;
  assign wr_state_dbg = wr_state;
  assign rd_state_dbg = rd_state;

endmodule

// File: tb/tb_axil_tile_regs.sv
// Self-checking bench for axil_tile_regs: directed scenarios plus randomized
// traffic checked against a byte-level register model.
module tb_axil_tile_regs;
  import axil_tile_pkg::*;

  logic         clk_control = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   S_AXI_AWADDR = '0;
  logic         S_AXI_AWVALID = 1'b0;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA = '0;
  logic [3:0]   S_AXI_WSTRB = '0;
  logic         S_AXI_WVALID = 1'b0;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY = 1'b0;
  logic [7:0]   S_AXI_ARADDR = '0;
  logic         S_AXI_ARVALID = 1'b0;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY = 1'b0;
  logic [383:0] ctrl_regs;
  logic [11:0]  wr_pulse;
  logic [127:0] status_in = '0;
  wr_state_t    wr_state_dbg;
  rd_state_t    rd_state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] model_regs [12];

  axil_tile_regs dut (
    .clk_control(clk_control), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .ctrl_regs(ctrl_regs),
    .wr_pulse(wr_pulse), .status_in(status_in),
    .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
  );

  // clock / reset
  always #5 clk_control = ~clk_control;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [383:0] model_flat();
    logic [383:0] f;
    for (int i = 0; i < 12; i++) f[32*i +: 32] = model_regs[i];
    return f;
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [5:0] idx);
    if (idx < 12) return 2'b00;
    if (idx < 16) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [5:0] idx);
    return (idx < 16) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [5:0] idx);
    if (idx < 12) return model_regs[idx];
    if (idx < 16) return status_in[32*(int'(idx)-12) +: 32];
    return 32'h0;
  endfunction

  // drivers: lead > 0 puts W that many cycles ahead of AW, lead < 0 the reverse
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int bdelay);
    int t_aw, t_w;
    bit aw_done, w_done, aw_f, w_f;
    logic [5:0] idx;
    logic [1:0] er;
    logic [11:0] ep;
    idx  = addr[7:2];
    er   = exp_bresp(idx);
    ep   = (idx < 12 && strb != 4'h0) ? (12'd1 << idx) : 12'd0;
    t_aw = (lead > 0) ? lead : 0;
    t_w  = (lead < 0) ? -lead : 0;
    if (idx < 12) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
    end
    aw_done = 0; w_done = 0;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      if (c == t_aw) begin S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1; end
      if (c == t_w)  begin S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1; end
      #1;
      aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
      w_f  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge clk_control);
      if (aw_f) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_f)  begin S_AXI_WVALID = 1'b0;  w_done = 1;  end
    end
    tests_run++;
    if (!(aw_done && w_done)) begin
      tests_failed++;
      $display("FAIL wr_handshake_timeout addr=%h aw_done=%0d w_done=%0d", addr, aw_done, w_done);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      return;
    end
    tests_run++;
    if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== er) begin
      tests_failed++;
      $display("FAIL bresp addr=%h got bvalid=%b bresp=%b want 1/%b", addr, S_AXI_BVALID, S_AXI_BRESP, er);
    end
    tests_run++;
    if (wr_pulse !== ep) begin
      tests_failed++;
      $display("FAIL wr_pulse addr=%h got %h want %h", addr, wr_pulse, ep);
    end
    tests_run++;
    if (ctrl_regs !== model_flat()) begin
      tests_failed++;
      $display("FAIL ctrl_regs after write addr=%h got %h want %h", addr, ctrl_regs, model_flat());
    end
    for (int k = 0; k < bdelay; k++) begin
      @(negedge clk_control);
      tests_run++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== er || S_AXI_AWREADY !== 1'b0 ||
          S_AXI_WREADY !== 1'b0 || wr_pulse !== 12'd0) begin
        tests_failed++;
        $display("FAIL b_hold cyc=%0d got bv=%b br=%b awr=%b wr=%b pulse=%h want 1/%b/0/0/0",
                 k, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY, wr_pulse, er);
      end
    end
    S_AXI_BREADY = 1'b1;
    @(negedge clk_control);
    S_AXI_BREADY = 1'b0;
    tests_run++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1 || wr_pulse !== 12'd0) begin
      tests_failed++;
      $display("FAIL b_done got bv=%b awr=%b wr=%b pulse=%h want 0/1/1/0",
               S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, wr_pulse);
    end
  endtask

  task automatic do_read(input logic [7:0] addr, input int rdelay);
    bit fired;
    logic [31:0] ed;
    logic [1:0] er;
    fired = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    er = exp_rresp(addr[7:2]);
    ed = 32'h0;
    for (int c = 0; c < 20 && !fired; c++) begin
      #1;
      fired = S_AXI_ARREADY;
      ed = exp_rdata(addr[7:2]);
      @(negedge clk_control);
    end
    S_AXI_ARVALID = 1'b0;
    tests_run++;
    if (!fired) begin
      tests_failed++;
      $display("FAIL ar_handshake_timeout addr=%h", addr);
      return;
    end
    tests_run++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== ed || S_AXI_RRESP !== er) begin
      tests_failed++;
      $display("FAIL rdata addr=%h got rv=%b rdata=%h rresp=%b want 1/%h/%b",
               addr, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, ed, er);
    end
    for (int k = 0; k < rdelay; k++) begin
      status_in = ~status_in;
      @(negedge clk_control);
      tests_run++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== ed || S_AXI_RRESP !== er || S_AXI_ARREADY !== 1'b0) begin
        tests_failed++;
        $display("FAIL r_hold cyc=%0d got rv=%b rdata=%h rresp=%b arr=%b want 1/%h/%b/0",
                 k, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY, ed, er);
      end
    end
    S_AXI_RREADY = 1'b1;
    @(negedge clk_control);
    S_AXI_RREADY = 1'b0;
    tests_run++;
    if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
      tests_failed++;
      $display("FAIL r_done got rv=%b arr=%b want 0/1", S_AXI_RVALID, S_AXI_ARREADY);
    end
  endtask

  // scenarios
  task automatic test_reset();
    for (int i = 0; i < 12; i++) model_regs[i] = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk_control);
    tests_run++;
    if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0 || S_AXI_ARREADY !== 1'b0) begin
      tests_failed++;
      $display("FAIL readies_in_reset got %b%b%b want 000", S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin
      tests_failed++;
      $display("FAIL readies_after_reset got %b%b%b want 111", S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY);
    end
    tests_run++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0 || S_AXI_BRESP !== 2'b00 ||
        S_AXI_RRESP !== 2'b00 || S_AXI_RDATA !== 32'h0 || ctrl_regs !== '0 || wr_pulse !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got bv=%b rv=%b br=%b rr=%b rd=%h pulse=%h want all zero",
               S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, wr_pulse);
    end
    @(negedge clk_control);
  endtask

  task automatic test_write_basic();
    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    tests_run++;
    if (ctrl_regs[32 +: 32] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL reg1_value got %h want deadbeef", ctrl_regs[32 +: 32]);
    end
    do_read(8'h04, 0);
  endtask

  task automatic test_write_w_first();
    do_write(8'h08, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_write(8'h08, 32'h11223344, 4'b0101, 3, 0);
    tests_run++;
    if (ctrl_regs[64 +: 32] !== 32'hFF22FF44) begin
      tests_failed++;
      $display("FAIL reg2_merge got %h want ff22ff44", ctrl_regs[64 +: 32]);
    end
    do_write(8'h0A, 32'h99887766, 4'b1010, -2, 1);
    do_write(8'h08, 32'h0BADF00D, 4'h0, 1, 0);
  endtask

  task automatic test_ro_decerr();
    do_write(8'h30, 32'h12345678, 4'hF, 0, 0);
    status_in = {96'h0, 32'hCAFE0001};
    do_read(8'h30, 0);
    do_read(8'h40, 0);
    do_write(8'h40, 32'h55AA55AA, 4'hF, 0, 0);
    status_in = {32'hA0A0A0A3, 32'hB0B0B0B2, 32'hC0C0C0C1, 32'hD0D0D0D0};
    do_read(8'h3C, 0);
    do_read(8'hFC, 0);
  endtask

  task automatic test_backpressure();
    do_write(8'h14, 32'h0F0F1234, 4'hF, 0, 5);
    status_in = {$urandom, $urandom, $urandom, $urandom};
    do_read(8'h34, 5);
    do_read(8'h14, 5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_write(8'(4 * (i + 4)), $urandom, 4'hF, 0, 0);
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] old_v, new_v;
    old_v = model_regs[3];
    new_v = ~old_v;
    S_AXI_AWADDR = 8'h0C; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = new_v;  S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 8'h0C; S_AXI_ARVALID = 1'b1;
    #1;
    tests_run++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_cycle_readies got %b%b%b want 111", S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY);
    end
    @(negedge clk_control);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    model_regs[3] = new_v;
    tests_run++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== old_v) begin
      tests_failed++;
      $display("FAIL same_cycle_read got rv=%b rdata=%h want 1/%h", S_AXI_RVALID, S_AXI_RDATA, old_v);
    end
    tests_run++;
    if (S_AXI_BVALID !== 1'b1 || ctrl_regs !== model_flat()) begin
      tests_failed++;
      $display("FAIL same_cycle_write got bv=%b reg3=%h want 1/%h", S_AXI_BVALID, ctrl_regs[96 +: 32], new_v);
    end
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(negedge clk_control);
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    tests_run++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle_done got bv=%b rv=%b want 0/0", S_AXI_BVALID, S_AXI_RVALID);
    end
  endtask

  task automatic test_random();
    logic [5:0] idx;
    logic [7:0] addr;
    for (int n = 0; n < 40; n++) begin
      idx  = 6'($urandom_range(0, 20));
      addr = {idx, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1)
        do_write(addr, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
      else begin
        status_in = {$urandom, $urandom, $urandom, $urandom};
        do_read(addr, int'($urandom_range(0, 3)));
      end
    end
  endtask

  task automatic test_reset_mid();
    S_AXI_WDATA = 32'h13579BDF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 8'h04; S_AXI_ARVALID = 1'b1;
    #1;
    @(negedge clk_control);
    S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    tests_run++;
    if (wr_state_dbg !== WR_WAIT || rd_state_dbg !== RD_RESP || S_AXI_RVALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_states got wr=%0d rd=%0d rv=%b want WR_WAIT/RD_RESP/1",
               wr_state_dbg, rd_state_dbg, S_AXI_RVALID);
    end
    rst = 1'b1;
    @(negedge clk_control);
    for (int i = 0; i < 12; i++) model_regs[i] = 32'h0;
    tests_run++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0 || S_AXI_RDATA !== 32'h0 ||
        ctrl_regs !== '0 || wr_pulse !== '0 || S_AXI_AWREADY !== 1'b0 ||
        S_AXI_WREADY !== 1'b0 || S_AXI_ARREADY !== 1'b0 || wr_state_dbg !== WR_IDLE) begin
      tests_failed++;
      $display("FAIL mid_reset got bv=%b rv=%b rd=%h awr=%b wr=%b arr=%b wr_st=%0d want zeros/idle",
               S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA, S_AXI_AWREADY, S_AXI_WREADY,
               S_AXI_ARREADY, wr_state_dbg);
    end
    rst = 1'b0;
    S_AXI_AWADDR = 8'h0C; S_AXI_AWVALID = 1'b1;
    #1;
    @(negedge clk_control);
    S_AXI_AWVALID = 1'b0;
    repeat (3) @(negedge clk_control);
    tests_run++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0 || wr_state_dbg !== WR_WAIT || ctrl_regs !== '0) begin
      tests_failed++;
      $display("FAIL stale_after_reset got bv=%b rv=%b wr_st=%0d want 0/0/WR_WAIT, regs zero",
               S_AXI_BVALID, S_AXI_RVALID, wr_state_dbg);
    end
    S_AXI_WDATA = 32'h5A5A5A5A; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    #1;
    @(negedge clk_control);
    S_AXI_WVALID = 1'b0;
    model_regs[3] = 32'h5A5A5A5A;
    tests_run++;
    if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00 || ctrl_regs !== model_flat()) begin
      tests_failed++;
      $display("FAIL post_reset_write got bv=%b br=%b reg3=%h want 1/00/5a5a5a5a",
               S_AXI_BVALID, S_AXI_BRESP, ctrl_regs[96 +: 32]);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge clk_control);
    S_AXI_BREADY = 1'b0;
  endtask

  initial begin
    @(negedge clk_control);
    test_reset();
    test_write_basic();
    test_write_w_first();
    test_ro_decerr();
    test_backpressure();
    test_back_to_back();
    test_rw_same_cycle();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axil_tile_regs.md
# axil_tile_regs

AXI4-Lite slave register file that terminates one tile's control port, directly downstream of the control-bus splitter that broadcasts address and data to every tile. It accepts AW/W/AR handshakes from its per-tile slice of the broadcast bus and returns B/R responses for the splitter to merge. It exposes read-write control registers to the tile datapath and read-only status words from it. One instance per tile.

## Interface
- AXI_OUTADR, 8, byte-address width from the splitter
- BW, 32, data width
- BWB, 4, strobe width (BW/8)
- NREGS, 16, total 32-bit registers, power of two, ≤ 2^(AXI_OUTADR-2)
- NRO, 4, read-only status registers, occupying the top NRO indices

Ports:
- clk_control  in  1  clock; the only clock
- rst  in  1  reset, synchronous, active-high
- S_AXI_AWADDR / AWVALID / AWREADY  in/in/out  AXI_OUTADR/1/1  write address channel
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  BW/BWB/1/1  write data channel
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response
- S_AXI_ARADDR / ARVALID / ARREADY  in/in/out  AXI_OUTADR/1/1  read address
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  BW/2/1/1  read data
- ctrl_regs  out  BW*(NREGS-NRO)  RW register contents, index i at bits [BW*i +: BW]
- wr_pulse  out  NREGS-NRO  one-cycle pulse per RW register written
- status_in  in  BW*NRO  RO status words, sampled at AR handshake

## Operation
- Index = addr[AXI_OUTADR-1:2]; addr[1:0] ignored.
- Index < NREGS-NRO: RW, RESP OKAY (2'b00). Index in [NREGS-NRO, NREGS-1]: RO; reads OKAY, writes discarded with SLVERR (2'b10). Index ≥ NREGS: DECERR (2'b11), write discarded, RDATA = 0.
- Byte merge: lane b of register updated only if WSTRB[b]; WSTRB = 0 is a legal no-op write returning OKAY, no wr_pulse.
- Write FSM: WR_IDLE → WR_WAIT when exactly one of AW/W handshakes; WR_IDLE/WR_WAIT → WR_RESP on the edge where both AW and W are held (commit edge); WR_RESP → WR_IDLE on BVALID&&BREADY.
- AWREADY = !aw_held && state≠WR_RESP; WREADY = !w_held && state≠WR_RESP. AW and W accepted in any order or same cycle.
- Read FSM: RD_IDLE (ARREADY=1) → RD_RESP on AR handshake, RDATA/RRESP registered that edge; RD_RESP (ARREADY=0) → RD_IDLE on RVALID&&RREADY.
- Read and write paths independent; both may be active simultaneously.
- Reset: all ctrl_regs = 0, wr_pulse = 0, BVALID = RVALID = 0, BRESP = RRESP = 0, RDATA = 0, FSMs idle, held flags clear. AWREADY/WREADY/ARREADY forced 0 while rst high. Reset mid-transaction drops it; no response issued afterward.

## Timing
- Write: commit at edge N → register value and wr_pulse visible cycle N+1, BVALID cycle N+1; BVALID, BRESP held stable until BREADY.
- BREADY high at cycle N+1 → AWREADY/WREADY high cycle N+2; peak one write per 2 cycles.
- Read: AR handshake at edge N → RVALID, RDATA, RRESP cycle N+1, held stable until RREADY; peak one read per 2 cycles.
- Same-cycle read handshake and write commit to same register: read returns pre-write value.
- Readies high first cycle after rst deasserts.

## Structure
- Package axil_tile_pkg: RESP_OKAY/RESP_SLVERR/RESP_DECERR constants, wr_state_t {WR_IDLE, WR_WAIT, WR_RESP}, rd_state_t {RD_IDLE, RD_RESP}, function strb_merge(old, wdata, wstrb).
- No sub-module; single module with two FSMs and a register array.

## Test plan
- AW+W same cycle, addr 0x04, data 0xDEADBEEF, WSTRB 4'hF → reg1 = 0xDEADBEEF, wr_pulse[1] one cycle, BVALID next cycle, BRESP 00.
- W three cycles before AW, addr 0x08, WSTRB 4'b0101, data 0x11223344 over 0xFFFFFFFF → reg2 = 0xFF22FF44, BVALID cycle after AW.
- Write addr 0x30 (RO index 12) → SLVERR, no register change; read 0x30 with status_in word0 = 0xCAFE0001 → RDATA 0xCAFE0001, OKAY.
- Read addr 0x40 (index 16) → RDATA 0, RRESP 11; write 0x40 → BRESP 11.
- BREADY/RREADY held low 5 cycles → BVALID/RVALID, BRESP/RDATA stable, AWREADY/WREADY/ARREADY low throughout.
- rst asserted while in WR_WAIT and RD_RESP → all outputs reset next edge, ctrl_regs 0, no stale BVALID/RVALID after release.
